// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master with chip-select decode.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        DONE
    } state_t;

    // {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    localparam int MAX_CS = 256;

    function automatic logic [MAX_CS-1:0] cs_mask(input logic [7:0] idx);
        return ~(MAX_CS'(1) << idx);
    endfunction

endpackage

// File: rtl/spi_cs_decoder.sv
// Combinational active-low slave-select decoder with range check.
module spi_cs_decoder
    import spi_pkg::*;
#(
    parameter int NUM_SLAVES = 16,
    parameter int SEL_W      = 4
) (
    input  logic [SEL_W-1:0]      index,
    input  logic                  enable,
    output logic [NUM_SLAVES-1:0] cs_n,
    output logic                  range_ok
);

    localparam logic [SEL_W:0] NUM_S = (SEL_W+1)'(NUM_SLAVES);

    logic [MAX_CS-1:0] mask_full;

    always_comb begin
        range_ok  = ({1'b0, index} < NUM_S);
        mask_full = cs_mask(8'(index));
        cs_n      = (enable && range_ok) ? mask_full[NUM_SLAVES-1:0] : '1;
    end

endmodule

// File: rtl/spi_master_cs.sv
// SPI master with programmable SCLK divider, CPOL/CPHA modes and decoded cs_n.
//
// state | meaning
// IDLE  | waiting for start; sclk parked at last cpol
// SETUP | cs asserted, first bit presented (cpha=0), H cycles
// XFER  | 2*DATA_W sclk edges, one every H cycles
// HOLD  | sclk idle, cs still asserted, H cycles
// DONE  | cs released, rx_data updated, done pulse
module spi_master_cs
    import spi_pkg::*;
#(
    parameter int NUM_SLAVES = 16,
    parameter int SEL_W      = 4,
    parameter int DATA_W     = 8,
    parameter int DIV_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [SEL_W-1:0]      slave_sel,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic [DIV_W-1:0]      clk_div,
    input  logic [DATA_W-1:0]     tx_data,
    input  logic                  miso,
    output logic [DATA_W-1:0]     rx_data,
    output logic                  busy,
    output logic                  done,
    output logic                  sel_err,
    output logic                  sclk,
    output logic                  mosi,
    output logic [NUM_SLAVES-1:0] cs_n
);

    localparam int EW = $clog2(2*DATA_W+1);
    localparam logic [EW-1:0] NUM_EDGES = EW'(2*DATA_W);

    state_t                state, state_nxt;
    logic [DIV_W:0]        cnt, cnt_nxt;
    logic [EW-1:0]         edge_cnt, edge_nxt;
    logic [DATA_W-1:0]     sh, sh_nxt;
    logic [DIV_W-1:0]      div_q, div_nxt;
    logic                  cpol_q, cpol_nxt, cpha_q, cpha_nxt;
    logic [NUM_SLAVES-1:0] cs_n_nxt, dec_cs_n;
    logic [DATA_W-1:0]     rx_nxt;
    logic                  sclk_nxt, mosi_nxt, done_nxt, sel_err_nxt, busy_nxt;
    logic                  range_ok, take_edge, lead;

    spi_cs_decoder #(.NUM_SLAVES(NUM_SLAVES), .SEL_W(SEL_W)) u_dec (
        .index    (slave_sel),
        .enable   (state == IDLE && start),
        .cs_n     (dec_cs_n),
        .range_ok (range_ok)
    );

    // edge_cnt counts edges already issued, so an even count means the next edge leads
    assign lead = ~edge_cnt[0];

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        edge_nxt    = edge_cnt;
        sh_nxt      = sh;
        div_nxt     = div_q;
        cpol_nxt    = cpol_q;
        cpha_nxt    = cpha_q;
        cs_n_nxt    = cs_n;
        rx_nxt      = rx_data;
        sclk_nxt    = sclk;
        mosi_nxt    = mosi;
        done_nxt    = 1'b0;
        sel_err_nxt = 1'b0;
        take_edge   = 1'b0;

        case (state)
            IDLE: begin
                sclk_nxt = cpol_q;
                mosi_nxt = 1'b0;
                cs_n_nxt = '1;
                if (start && range_ok) begin
                    state_nxt = SETUP;
                    cpol_nxt  = cpol;
                    cpha_nxt  = cpha;
                    div_nxt   = clk_div;
                    cnt_nxt   = {1'b0, clk_div};
                    edge_nxt  = '0;
                    sh_nxt    = tx_data;
                    cs_n_nxt  = dec_cs_n;
                    sclk_nxt  = cpol;
                    mosi_nxt  = cpha ? 1'b0 : tx_data[DATA_W-1];
                end else if (start) begin
                    sel_err_nxt = 1'b1;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_nxt = XFER;
                    take_edge = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            XFER: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else if (edge_cnt == NUM_EDGES) begin
                    state_nxt = HOLD;
                    cnt_nxt   = {1'b0, div_q};
                end else begin
                    take_edge = 1'b1;
                end
            end
            HOLD: begin
                sclk_nxt = cpol_q;
                if (cnt == '0) begin
                    state_nxt = DONE;
                    cs_n_nxt  = '1;
                    done_nxt  = 1'b1;
                    rx_nxt    = sh;
                    mosi_nxt  = 1'b0;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                mosi_nxt  = 1'b0;
            end
            default: state_nxt = IDLE;
        endcase

        if (take_edge) begin
            cnt_nxt  = {1'b0, div_q};
            edge_nxt = edge_cnt + 1'b1;
            sclk_nxt = ~sclk;
            if (lead) begin
                if (cpha_q) mosi_nxt = sh[DATA_W-1];
                else        sh_nxt   = {sh[DATA_W-2:0], miso};
            end else begin
                if (cpha_q)                            sh_nxt   = {sh[DATA_W-2:0], miso};
                else if (edge_cnt != NUM_EDGES - 1'b1) mosi_nxt = sh[DATA_W-1];
            end
        end

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            edge_cnt <= '0;
            sh       <= '0;
            div_q    <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            cs_n     <= '1;
            rx_data  <= '0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            done     <= 1'b0;
            sel_err  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            edge_cnt <= edge_nxt;
            sh       <= sh_nxt;
            div_q    <= div_nxt;
            cpol_q   <= cpol_nxt;
            cpha_q   <= cpha_nxt;
            cs_n     <= cs_n_nxt;
            rx_data  <= rx_nxt;
            sclk     <= sclk_nxt;
            mosi     <= mosi_nxt;
            done     <= done_nxt;
            sel_err  <= sel_err_nxt;
            busy     <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_spi_master_cs.sv
// Scoreboard bench for spi_master_cs: 16-slave instance with a slave model, plus a 12-slave instance for range errors.
module tb_spi_master_cs;
    import spi_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start16 = 1'b0, start12 = 1'b0;
    logic [3:0]  slave_sel = '0;
    logic        cpol = 1'b0, cpha = 1'b0;
    logic [7:0]  clk_div = '0;
    logic [7:0]  tx_data = '0;
    logic        miso16, miso12;

    logic [7:0]  rx16, rx12;
    logic        busy16, busy12, done16, done12, sel_err16, sel_err12;
    logic        sclk16, sclk12, mosi16, mosi12;
    logic [15:0] cs_n16;
    logic [11:0] cs_n12;

    spi_master_cs #(.NUM_SLAVES(16), .SEL_W(4), .DATA_W(8), .DIV_W(8)) u16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .slave_sel(slave_sel),
        .cpol(cpol), .cpha(cpha), .clk_div(clk_div), .tx_data(tx_data),
        .miso(miso16), .rx_data(rx16), .busy(busy16), .done(done16),
        .sel_err(sel_err16), .sclk(sclk16), .mosi(mosi16), .cs_n(cs_n16)
    );

    spi_master_cs #(.NUM_SLAVES(12), .SEL_W(4), .DATA_W(8), .DIV_W(8)) u12 (
        .clk(clk), .rst_n(rst_n), .start(start12), .slave_sel(slave_sel),
        .cpol(cpol), .cpha(cpha), .clk_div(clk_div), .tx_data(tx_data),
        .miso(miso12), .rx_data(rx12), .busy(busy12), .done(done12),
        .sel_err(sel_err12), .sclk(sclk12), .mosi(mosi12), .cs_n(cs_n12)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  rx;
        int          cyc;
        logic [15:0] cs;
        logic [7:0]  mw;
        int          h;
    } exp_t;
    exp_t q[$];

    // slave model for u16
    logic       loop = 1'b0;
    logic       m_cpol = 1'b0, m_cpha = 1'b0;
    logic [7:0] s_tx = '0, s_rx = '0;
    logic       s_miso = 1'b0;
    int         bi = 7;
    assign miso16 = loop ? mosi16 : s_miso;
    assign miso12 = mosi12;

    logic [15:0] cs_prev = '1;
    logic        sclk_prev = 1'b0;
    int          tog = 0, last_tog = 0, done_cnt = 0;
    logic        cs_bad = 1'b0, int_bad = 1'b0;

    always @(negedge clk) begin
        if (cs_n16 != '1 && cs_prev == '1) begin
            bi = 7; s_rx = '0; tog = 0; cs_bad = 1'b0; int_bad = 1'b0;
            if (!m_cpha) s_miso = s_tx[7];
        end else if (cs_n16 != '1 && sclk16 != sclk_prev) begin
            if (sclk_prev == m_cpol) begin
                if (m_cpha) s_miso = s_tx[bi];
                else        s_rx   = {s_rx[6:0], mosi16};
            end else begin
                if (m_cpha) begin
                    s_rx = {s_rx[6:0], mosi16};
                    if (bi > 0) bi--;
                end else if (bi > 0) begin
                    bi--;
                    s_miso = s_tx[bi];
                end
            end
            if (tog > 0 && q.size() > 0 && (cyc - last_tog) != q[0].h) int_bad = 1'b1;
            tog++;
            last_tog = cyc;
        end
        if (cs_n16 != '1 && q.size() > 0 && cs_n16 != q[0].cs) cs_bad = 1'b1;
        if (done16) begin
            done_cnt++;
            if (q.size() == 0) begin
                chk("done_unexpected", 32'(done16), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_rx_data", 32'(rx16), 32'(e.rx));
                chk("sb_done_cycle", cyc, e.cyc);
                chk("sb_sclk_edges", tog, 16);
                chk("sb_cs_n_active", 32'(cs_bad), 32'd0);
                chk("sb_half_period", 32'(int_bad), 32'd0);
                chk("sb_mosi_word", 32'(s_rx), 32'(e.mw));
                chk("sb_cs_n_done", 32'(cs_n16), 32'hFFFF);
            end
        end
        cs_prev   = cs_n16;
        sclk_prev = sclk16;
    end

    task automatic go(input logic [3:0] sel, input logic [1:0] mode, input logic [7:0] div,
                      input logic [7:0] tx, input logic [7:0] srx, input bit push, output int c);
        exp_t e;
        @(negedge clk);
        slave_sel = sel; {cpol, cpha} = mode; {m_cpol, m_cpha} = mode;
        clk_div = div; tx_data = tx; s_tx = srx; start16 = 1'b1;
        c = cyc;
        if (push) begin
            e.rx = srx; e.cyc = c + 1 + 18 * (int'(div) + 1);
            e.cs = ~(16'h1 << sel); e.mw = tx; e.h = int'(div) + 1;
            q.push_back(e);
        end
        @(negedge clk);
        start16 = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while ((busy16 || busy12 || q.size() != 0) && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(n < lim), 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, n;
        logic s0;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", 32'(cs_n16), 32'hFFFF);
        chk("rst_sclk", 32'(sclk16), 32'd0);
        chk("rst_mosi", 32'(mosi16), 32'd0);
        chk("rst_rx", 32'(rx16), 32'd0);
        chk("rst_busy_done_err", {busy16, done16, sel_err16}, 32'd0);
        chk("rst_cs_n12", 32'(cs_n12), 32'hFFF);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: mode 0 loopback
        loop = 1'b1;
        go(4'd3, MODE0, 8'd0, 8'hA5, 8'hA5, 1'b1, c);
        wait_cyc(c + 1);
        chk("t1_cs_n_setup", 32'(cs_n16), 32'hFFF7);
        chk("t1_mosi_setup", 32'(mosi16), 32'd1);
        wait_cyc(c + 19);
        chk("t1_done_c19", 32'(done16), 32'd1);
        chk("t1_busy_c19", 32'(busy16), 32'd1);
        wait_cyc(c + 20);
        chk("t1_busy_c20", 32'(busy16), 32'd0);
        wait_idle(200);

        // 2: mode 3, half-period 3, slave returns C3
        loop = 1'b0;
        go(4'd15, MODE3, 8'd2, 8'h3C, 8'hC3, 1'b1, c);
        wait_cyc(c + 2);
        chk("t2_cs_n", 32'(cs_n16), 32'h7FFF);
        chk("t2_sclk_setup", 32'(sclk16), 32'd1);
        wait_idle(200);
        chk("t2_sclk_idle", 32'(sclk16), 32'd1);

        // 3: out-of-range select on the 12-slave instance, then the top legal index
        @(negedge clk);
        slave_sel = 4'd13; start12 = 1'b1; s0 = sclk12;
        @(negedge clk);
        start12 = 1'b0;
        chk("t3_sel_err", 32'(sel_err12), 32'd1);
        chk("t3_busy", 32'(busy12), 32'd0);
        chk("t3_cs_n", 32'(cs_n12), 32'hFFF);
        @(negedge clk);
        chk("t3_sel_err_pulse", 32'(sel_err12), 32'd0);
        chk("t3_sclk_still", 32'(sclk12), 32'(s0));
        chk("t3_busy_after", 32'(busy12), 32'd0);
        slave_sel = 4'd11; start12 = 1'b1;
        @(negedge clk);
        start12 = 1'b0;
        chk("t3_sel11_busy", 32'(busy12), 32'd1);
        chk("t3_sel11_cs_n", 32'(cs_n12), 32'h7FF);
        chk("t3_sel11_err", 32'(sel_err12), 32'd0);
        wait_idle(200);

        // 4: start mid-transfer and across DONE
        loop = 1'b1;
        go(4'd5, MODE0, 8'd0, 8'h69, 8'h69, 1'b1, c);
        wait_cyc(c + 8);
        tx_data = 8'hFF; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        wait_cyc(c + 18);
        tx_data = 8'h5A; start16 = 1'b1;
        begin
            exp_t e;
            e.rx = 8'h5A; e.cyc = c + 39; e.cs = 16'hFFDF; e.mw = 8'h5A; e.h = 1;
            q.push_back(e);
        end
        wait_cyc(c + 21);
        start16 = 1'b0;
        wait_idle(200);

        // 5: reset after the 5th sclk edge of a mode 1 transfer
        loop = 1'b0;
        go(4'd2, MODE1, 8'd0, 8'hF0, 8'h0F, 1'b0, c);
        n = 0;
        while (tog < 5 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t5_edge_timeout", 32'(n < 50), 32'd1);
        n = done_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t5_cs_n", 32'(cs_n16), 32'hFFFF);
        chk("t5_sclk", 32'(sclk16), 32'd0);
        chk("t5_busy", 32'(busy16), 32'd0);
        chk("t5_rx", 32'(rx16), 32'd0);
        repeat (30) @(negedge clk);
        chk("t5_no_done", done_cnt, n);

        // 6: mode 1 vs mode 2, clk_div=1
        go(4'd7, MODE1, 8'd1, 8'h81, 8'h5A, 1'b1, c);
        wait_idle(200);
        go(4'd8, MODE2, 8'd1, 8'h81, 8'hB4, 1'b1, c);
        wait_idle(200);
        chk("t6_sclk_idle", 32'(sclk16), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
